// File: rtl/shift_reg_univ_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states
// and a helper that tells shifting modes apart from HOLD/LOAD/reserved.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic isShift(input mode_e m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Request/response bundle for the universal shift register; the requester
// drives the master side, the register sits on the slave side.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             i;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             so_l;
    logic             so_r;
    logic             busy;
    logic             done;

    modport master (
        output en, start, mode, amount, i, d,
        input  q, so_l, so_r, busy, done
    );

    modport slave (
        input  en, start, mode, amount, i, d,
        output q, so_l, so_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ_step.sv
// Single-step next-value function: one bit of shift/rotate for the given mode.
// Non-shifting modes pass the current value through unchanged.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             i_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] q_o
);

    always_comb begin
        q_o = q_i;
        case (mode_i)
            MODE_SHL: q_o = {q_i[WIDTH-2:0], i_i};
            MODE_SHR: q_o = {i_i, q_i[WIDTH-1:1]};
            MODE_ROL: q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR: q_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR: q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default:  q_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: multi-step shift/rotate controlled by an
// IDLE/SHIFT/DONE FSM, one bit per enabled clock edge.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    shift_reg_univ_if.slave  bus
);

    state_e           state_q;
    mode_e            mode_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] stepQ_d;
    mode_e            modeIn;
    mode_e            stepMode;

    assign modeIn   = mode_e'(bus.mode);
    // The accepting edge already performs the first step, so it uses the live mode.
    assign stepMode = (state_q == ST_SHIFT) ? mode_q : modeIn;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i    (q_q),
        .i_i    (bus.i),
        .mode_i (stepMode),
        .q_o    (stepQ_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
            count_q <= '0;
        end else if (bus.en) begin
            case (state_q)
                ST_SHIFT: begin
                    q_q     <= stepQ_d;
                    count_q <= count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    if (bus.start) begin
                        state_q <= ST_DONE;
                        if (modeIn == MODE_LOAD) begin
                            q_q <= bus.d;
                        end else if (isShift(modeIn) && (bus.amount != '0)) begin
                            q_q     <= stepQ_d;
                            mode_q  <= modeIn;
                            count_q <= bus.amount - CNT_W'(1);
                            if (bus.amount != CNT_W'(1)) begin
                                state_q <= ST_SHIFT;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.so_l = q_q[WIDTH-1];
    assign bus.so_r = q_q[0];
    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8): hand-computed vectors checked
// with immediate assertions, sampled on the falling clock edge.
module tb_shift_reg_univ;
    import shift_pkg::*;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    int   edges;

    shift_reg_univ_if #(.WIDTH(8)) bus ();

    shift_reg_univ #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic st, input mode_e md, input logic [3:0] amt,
                                 input logic ii, input logic [7:0] dd);
        bus.start  = st;
        bus.mode   = md;
        bus.amount = amt;
        bus.i      = ii;
        bus.d      = dd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkState(input string tag, input logic [7:0] expQ,
                              input logic expBusy, input logic expDone);
        checkOutput({tag, "_q"},    {24'd0, bus.q}, {24'd0, expQ});
        checkOutput({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, expBusy});
        checkOutput({tag, "_done"}, {31'd0, bus.done}, {31'd0, expDone});
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst    = 1'b1;
        bus.en = 1'b1;
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        #1;
        checkState("reset", 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // LOAD A5: immediate load, one-cycle done, never busy
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'hA5);
        tick();
        checkState("load", 8'hA5, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("load_idle", 8'hA5, 1'b0, 1'b0);

        // ROL 3 from 81
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'h81);
        tick();
        applyStimulus(1'b1, MODE_ROL, 4'd3, 1'b0, 8'h00);
        tick();
        checkState("rol_1", 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("rol_2", 8'h06, 1'b1, 1'b0);
        tick();
        checkState("rol_3", 8'h0C, 1'b0, 1'b1);
        checkOutput("rol_so_l", {31'd0, bus.so_l}, 32'd0);
        checkOutput("rol_so_r", {31'd0, bus.so_r}, 32'd0);
        tick();
        checkState("rol_idle", 8'h0C, 1'b0, 1'b0);

        // ASR 2 from 90, then ASR 0 from DONE
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'h90);
        tick();
        applyStimulus(1'b1, MODE_ASR, 4'd2, 1'b0, 8'h00);
        tick();
        checkState("asr_1", 8'hC8, 1'b1, 1'b0);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("asr_2", 8'hE4, 1'b0, 1'b1);
        checkOutput("asr_so_l", {31'd0, bus.so_l}, 32'd1);
        applyStimulus(1'b1, MODE_ASR, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("asr_zero", 8'hE4, 1'b0, 1'b1);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("asr_idle", 8'hE4, 1'b0, 1'b0);

        // SHL i=1 amount 4 with an ignored LOAD mid-operation
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, MODE_SHL, 4'd4, 1'b1, 8'h00);
        tick();
        checkState("shl_1", 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b1, 8'hAA);
        tick();
        checkState("shl_2", 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b1, 8'h00);
        tick();
        checkState("shl_3", 8'h07, 1'b1, 1'b0);
        tick();
        checkState("shl_4", 8'h0F, 1'b0, 1'b1);
        checkOutput("shl_so_l", {31'd0, bus.so_l}, 32'd0);
        checkOutput("shl_so_r", {31'd0, bus.so_r}, 32'd1);

        // SHR 5 from F0 with en low for 3 cycles after the second step
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'hF0);
        tick();
        applyStimulus(1'b1, MODE_SHR, 4'd5, 1'b0, 8'h00);
        tick();
        checkState("shr_1", 8'h78, 1'b1, 1'b0);
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        tick();
        checkState("shr_2", 8'h3C, 1'b1, 1'b0);
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkState($sformatf("shr_frozen%0d", k), 8'h3C, 1'b1, 1'b0);
        end
        bus.en = 1'b1;
        tick();
        checkState("shr_3", 8'h1E, 1'b1, 1'b0);
        tick();
        checkState("shr_4", 8'h0F, 1'b1, 1'b0);
        tick();
        checkState("shr_5", 8'h07, 1'b0, 1'b1);
        bus.en = 1'b0;
        tick();
        checkState("done_frozen", 8'h07, 1'b0, 1'b1);
        bus.en = 1'b1;
        tick();
        checkState("done_release", 8'h07, 1'b0, 1'b0);

        // Reserved mode behaves like HOLD
        applyStimulus(1'b1, MODE_RSVD, 4'd3, 1'b1, 8'hFF);
        tick();
        checkState("rsvd", 8'h07, 1'b0, 1'b1);

        // ROR 9 on A5 wraps to a single rotate: D2 after 9 edges
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'hA5);
        tick();
        applyStimulus(1'b1, MODE_ROR, 4'd9, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b0, 8'h00);
        edges = 1;
        while (!bus.done && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput("ror9_edges", edges, 32'd9);
        checkState("ror9", 8'hD2, 1'b0, 1'b1);

        // SHL 10 with i=1 saturates to FF after 10 edges
        applyStimulus(1'b1, MODE_SHL, 4'd10, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b1, 8'h00);
        edges = 1;
        while (!bus.done && edges < 20) begin
            tick();
            edges++;
        end
        checkOutput("shl10_edges", edges, 32'd10);
        checkState("shl10", 8'hFF, 1'b0, 1'b1);

        // Asynchronous reset mid-SHIFT, between clock edges
        applyStimulus(1'b1, MODE_LOAD, 4'd0, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b1, MODE_SHL, 4'd6, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, MODE_HOLD, 4'd0, 1'b1, 8'h00);
        tick();
        checkState("pre_rst", 8'h03, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkState("async_rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkState($sformatf("post_rst%0d", k), 8'h00, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
